op_resp_checker: RTL

- Response-side counterpart to the OP_F stimulus sequence.
- Samples the applied 4-bit vector {a,b,c,d} together with the observed OP_F outputs y and z.
- Compares y and z against a parameterised 16-entry truth table and tracks vector ordering, error count and first failing index.
- Reports done and pass/fail after all 16 vectors; sits alongside OP_F as a synthesisable self-check.

---
 rtl/op_resp_checker.sv | 128 ++++++++++++
 1 files changed

// File: rtl/op_resp_checker.sv
// op_resp_checker: response-side self-check for the OP_F stimulus sequence.
// Samples {a,b,c,d} with observed y/z, compares against EXP_Y/EXP_Z truth
// tables, tracks vector ordering, error count and first failing index.
// Optional feature: define OP_RESP_SIG_EN to add the 8-bit MISR output sig.
module op_resp_checker #(
   parameter logic [15:0] EXP_Y   = 16'h6996,
   parameter logic [15:0] EXP_Z   = 16'h8000,
   parameter int unsigned NUM_VEC = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       vld,
   input  logic       a,
   input  logic       b,
   input  logic       c,
   input  logic       d,
   input  logic       y,
   input  logic       z,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [4:0] err_cnt,
   output logic       first_err_vld,
   output logic [3:0] first_err_idx,
   output logic       seq_err
`ifdef OP_RESP_SIG_EN
   ,
   output logic [7:0] sig
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state;
   state_t     state_nxt;

   logic [4:0] vec_cnt;
   logic [3:0] idx;
   logic       accept;
   logic       clear;
   logic       last;
   logic       mismatch;
   logic       seq_nxt;
   logic [4:0] err_nxt;

   // sample decode: start outside RUN clears (and beats vld); vld only counts in RUN
   always_comb begin
      idx      = {a, b, c, d};
      accept   = (state == RUN) && vld;
      clear    = (state != RUN) && start;
      last     = accept && (vec_cnt == 5'(NUM_VEC - 1));
      mismatch = (y != EXP_Y[idx]) || (z != EXP_Z[idx]);
      seq_nxt  = seq_err || ({1'b0, idx} != vec_cnt);
      err_nxt  = err_cnt;
      if (mismatch && (err_cnt != 5'd16))
         err_nxt = err_cnt + 5'd1;
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last)  state_nxt = DONE;
         DONE:    if (start) state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
   end

   // state-decoded outputs
   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

   // result tracking; pass is computed from the final sample's updated values
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         vec_cnt       <= '0;
         err_cnt       <= '0;
         first_err_vld <= 1'b0;
         first_err_idx <= '0;
         seq_err       <= 1'b0;
         pass          <= 1'b0;
      end else if (accept) begin
         vec_cnt <= vec_cnt + 5'd1;
         err_cnt <= err_nxt;
         seq_err <= seq_nxt;
         pass    <= last && (err_nxt == 5'd0) && !seq_nxt;
         if (mismatch && !first_err_vld) begin
            first_err_vld <= 1'b1;
            first_err_idx <= idx;
         end
      end
   end

`ifdef OP_RESP_SIG_EN
   logic [7:0] sig_nxt;

   // MISR x^8+x^6+x^5+x^4+1: shift with feedback, then fold {y,z} into [1:0]
   always_comb begin
      sig_nxt = {sig[6:0], 1'b0} ^ (sig[7] ? 8'h71 : 8'h00);
      sig_nxt = sig_nxt ^ {6'b0, y, z};
   end

   // signature register; frozen outside RUN because only accepted samples advance it
   always_ff @(posedge clk) begin
      if (rst || clear)
         sig <= '1;
      else if (accept)
         sig <= sig_nxt;
   end
`endif

endmodule
